// File: rtl/ts_arb_pkg.sv
// Shared types for the time-surface BRAM port arbiter.
package ts_arb_pkg;

  localparam int TS_CELLS      = 256;
  localparam int TS_ADDR_BITS  = 8;
  localparam int TS_VALUE_BITS = 8;

  typedef enum logic [1:0] {
    G_IDLE  = 2'd0,
    G_SCAN  = 2'd1,
    G_EVENT = 2'd2,
    G_DEBUG = 2'd3
  } grant_t;

  // Event write record at the default cell geometry.
  typedef struct packed {
    logic [TS_ADDR_BITS-1:0]  addr;
    logic [TS_VALUE_BITS-1:0] wdata;
  } ts_event_t;

endpackage

// File: rtl/ts_event_fifo.sv
// Synchronous FIFO buffering event writes; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module ts_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (PW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage kept out of the reset branch so it can map to distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ts_port_arbiter.sv
// Arbitrates the single-port time-surface BRAM between scan reads, buffered
// event writes and debug reads. Optional statistics: define TS_ARB_STATS_EN.
import ts_arb_pkg::*;

module ts_port_arbiter #(
  parameter int VALUE_BITS    = 8,
  parameter int ADDR_BITS     = 8,
  parameter int EV_FIFO_DEPTH = 8,
  parameter int DBG_MAX_WAIT  = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ev_valid,
  input  logic [ADDR_BITS-1:0]            ev_addr,
  input  logic [VALUE_BITS-1:0]           ev_wdata,
  output logic                            ev_drop,
  input  logic                            sc_read_enable,
  input  logic [ADDR_BITS-1:0]            sc_read_addr,
  output logic [VALUE_BITS-1:0]           sc_read_value,
  input  logic                            dbg_req,
  input  logic [ADDR_BITS-1:0]            dbg_addr,
  output logic                            dbg_ack,
  output logic [VALUE_BITS-1:0]           dbg_rdata,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_BITS-1:0]            mem_addr,
  output logic [VALUE_BITS-1:0]           mem_wdata,
  input  logic [VALUE_BITS-1:0]           mem_rdata,
  output logic [$clog2(EV_FIFO_DEPTH):0]  ev_fifo_level
`ifdef TS_ARB_STATS_EN
  ,
  input  logic                            stat_clear,
  output logic [15:0]                     stat_drop_count,
  output logic [$clog2(EV_FIFO_DEPTH):0]  stat_max_level
`endif
);

  localparam int EW = ADDR_BITS + VALUE_BITS;
  localparam int WW = $clog2(DBG_MAX_WAIT + 1);

  grant_t                grant;
  grant_t                gstate;
  logic [WW-1:0]         wait_cnt;
  logic [VALUE_BITS-1:0] dbg_hold;
  logic                  inflight;
  logic                  promoted;
  logic                  drop_now;

  logic [EW-1:0]         fifo_din;
  logic [EW-1:0]         fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic                  fifo_push;
  logic [ADDR_BITS-1:0]  head_addr;
  logic [VALUE_BITS-1:0] head_wdata;

  assign fifo_din   = {ev_addr, ev_wdata};
  assign head_addr  = fifo_dout[EW-1:VALUE_BITS];
  assign head_wdata = fifo_dout[VALUE_BITS-1:0];
  assign fifo_push  = ev_valid && !rst;
  assign fifo_pop   = (grant == G_EVENT);
  assign drop_now   = ev_valid && fifo_full && !fifo_pop;

  ts_event_fifo #(
    .DEPTH (EV_FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (ev_fifo_level)
  );

  // A debug read granted last cycle returns data now; no second grant yet.
  assign inflight = (gstate == G_DEBUG);
  assign promoted = (wait_cnt >= WW'(DBG_MAX_WAIT));

  always_comb begin
    grant = G_IDLE;
    if (!rst) begin
      if (sc_read_enable) begin
        grant = G_SCAN;
      end else if (dbg_req && promoted && !inflight) begin
        grant = G_DEBUG;
      end else if (!fifo_empty) begin
        grant = G_EVENT;
      end else if (dbg_req && !inflight) begin
        grant = G_DEBUG;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (grant)
      G_SCAN: begin
        mem_en   = 1'b1;
        mem_addr = sc_read_addr;
      end
      G_EVENT: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head_addr;
        mem_wdata = head_wdata;
      end
      G_DEBUG: begin
        mem_en   = 1'b1;
        mem_addr = dbg_addr;
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gstate   <= G_IDLE;
      wait_cnt <= '0;
      ev_drop  <= 1'b0;
      dbg_hold <= '0;
    end else begin
      gstate  <= grant;
      ev_drop <= drop_now;
      if (inflight) begin
        dbg_hold <= mem_rdata;
      end
      if (grant == G_DEBUG) begin
        wait_cnt <= '0;
      end else if (dbg_req && !inflight && !promoted) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Read data is presented during the ack cycle and held afterwards.
  assign sc_read_value = mem_rdata;
  assign dbg_ack       = inflight && !rst;
  assign dbg_rdata     = dbg_ack ? mem_rdata : dbg_hold;

`ifdef TS_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stat_clear) begin
      stat_drop_count <= '0;
      stat_max_level  <= '0;
    end else begin
      if (drop_now && (stat_drop_count != '1)) begin
        stat_drop_count <= stat_drop_count + 1'b1;
      end
      if (ev_fifo_level > stat_max_level) begin
        stat_max_level <= ev_fifo_level;
      end
    end
  end
`else
  // Statistics counters are compiled out in this build.
`endif

endmodule
